// File: rtl/start_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : start_gen_pkg
//  Description : Shared definitions for the start_gen block: request FSM
//                state encoding and default parameter values.
//  Revision    : 1.0  initial release
// ============================================================================
package start_gen_pkg;

    // Default timing parameters, in clk cycles.
    localparam int unsigned c_DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned c_DEFAULT_REPEAT_CYCLES   = 64;

    // Request FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,   // no request outstanding
        PEND = 2'b01,   // one press waiting for downstream to go idle
        HELD = 2'b10    // request issued, waiting for button release
    } state_t;

endpackage : start_gen_pkg
`default_nettype wire

// File: rtl/start_gen_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Two-flop synchronizer followed by a saturating-style
//                mismatch counter. The debounced level flips only after the
//                synchronized input has disagreed with it on
//                DEBOUNCE_CYCLES consecutive clock edges; any single cycle
//                of agreement restarts the count.
//  Ports       : clk  - clock, rising-edge active
//                rst  - synchronous active-high reset
//                din  - raw asynchronous input
//                dout - debounced, registered level
//  Revision    : 1.0  initial release
// ============================================================================
module debounce
    import start_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned              c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]       c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // Mismatch persisted for the full window: accept new level.
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dout = r_level;

endmodule : debounce
`default_nettype wire

// File: rtl/start_gen.sv
`default_nettype none
// ============================================================================
//  Module      : start_gen
//  Description : Turns a raw push-button into single start requests for a
//                downstream pulse generator. The button is synchronized and
//                debounced; each debounced rising edge is a press. A press
//                while downstream is busy is held (at most one) and issued
//                when busy drops; further presses while one is held are
//                reported on drop.
//  Config      : START_GEN_REPEAT_EN - when defined, a button held in HELD
//                re-issues a request every REPEAT_CYCLES cycles.
//  Ports       : clk   - clock, rising-edge active
//                rst   - synchronous active-high reset
//                btn   - raw asynchronous button level
//                busy  - downstream pulse generator active
//                start - registered one-cycle request pulse
//                level - debounced button level (registered)
//                drop  - registered one-cycle pulse, press discarded
//  Revision    : 1.0  initial release
// ============================================================================
module start_gen
    import start_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = c_DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic busy,
    output logic start,
    output logic level,
    output logic drop
);

    // Both counters need at least two states to be meaningful.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("start_gen: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic   w_level;
    logic   r_level_prev;
    logic   w_press;
    state_t r_state;
    state_t w_state_nxt;
    logic   w_start_nxt;
    logic   w_drop_nxt;
    logic   r_start;
    logic   r_drop;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn),
        .dout (w_level)
    );

    // Press = debounced level rose on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= w_level;
        end
    end

    assign w_press = w_level & ~r_level_prev;

`ifdef START_GEN_REPEAT_EN
    localparam int unsigned        c_REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               w_repeat;

    // Runs only while the request is held; restarts on every HELD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (r_state != HELD || r_rep_cnt == c_REP_LAST) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_repeat = (r_state == HELD) && (r_rep_cnt == c_REP_LAST);
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_drop_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    if (!busy) begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = HELD;
                    end else begin
                        w_state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (!busy) begin
                    // Issue the held request; a release during the wait
                    // means there is nothing left to hold.
                    w_start_nxt = 1'b1;
                    w_state_nxt = w_level ? HELD : IDLE;
                end else if (w_press) begin
                    w_drop_nxt = 1'b1;
                end
            end
            HELD: begin
                // Release takes precedence over a coincident repeat tick.
                if (!w_level) begin
                    w_state_nxt = IDLE;
                end
`ifdef START_GEN_REPEAT_EN
                else if (w_repeat) begin
                    if (!busy) begin
                        w_start_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PEND;
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign start = r_start;
    assign drop  = r_drop;
    assign level = w_level;

endmodule : start_gen
`default_nettype wire

// File: tb/tb_start_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_start_gen
//  Description : Self-checking bench for start_gen (DEBOUNCE_CYCLES=4,
//                REPEAT_CYCLES=8). Stimulus pushes expected start/drop
//                pulses with their cycle number into a queue; a monitor pops
//                and compares whenever the DUT raises start or drop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_start_gen;
    import start_gen_pkg::*;

    localparam int c_D = 4;
    localparam int c_R = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic busy;
    logic start;
    logic level;
    logic drop;

    start_gen #(
        .DEBOUNCE_CYCLES (c_D),
        .REPEAT_CYCLES   (c_R)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .busy  (busy),
        .start (start),
        .level (level),
        .drop  (drop)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable when sampled at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_drop;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input bit is_drop);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, none expected",
                     is_drop ? "drop" : "start", cyc);
        end else begin
            e = q.pop_front();
            if (e.is_drop != is_drop || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                         is_drop ? "drop" : "start", cyc,
                         e.is_drop ? "drop" : "start", e.cyc);
            end
        end
    endtask

    // Monitor: every start/drop pulse must match the head of the queue.
    always @(negedge clk) begin
        if (start === 1'b1) pop_check(1'b0);
        if (drop === 1'b1)  pop_check(1'b1);
    end

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_pulse(input bit is_drop, input int c);
        exp_t e;
        e.is_drop = is_drop;
        e.cyc     = c;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        rst  = 1'b1;
        btn  = 1'b0;
        busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_start", 32'(start), 32'd0);
        check("reset_drop",  32'(drop),  32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press, busy low: level at edge 6, start at edge 7.
        t0  = cyc;
        btn = 1'b1;
        expect_pulse(1'b0, t0 + 7);
`ifdef START_GEN_REPEAT_EN
        expect_pulse(1'b0, t0 + 15);
        expect_pulse(1'b0, t0 + 23);
`endif
        at(t0 + 5);  check("s1_level_e5", 32'(level), 32'd0);
        at(t0 + 6);  check("s1_level_e6", 32'(level), 32'd1);
        at(t0 + 8);  check("s1_state_held", 32'(dut.r_state), 32'(HELD));
        at(t0 + 20); btn = 1'b0;
        at(t0 + 26); check("s1_level_released", 32'(level), 32'd0);
        at(t0 + 35); check("s1_state_idle", 32'(dut.r_state), 32'(IDLE));

        // Glitchy input: 3 high / 1 low never completes the window.
        for (int i = 0; i < 4; i++) begin
            t0  = cyc;
            btn = 1'b1;
            at(t0 + 3);
            btn = 1'b0;
            at(t0 + 4);
            check("s2_level_glitch", 32'(level), 32'd0);
        end
        at(cyc + 10);
        check("s2_level_after", 32'(level), 32'd0);

        // Press while busy: held, then issued one cycle after busy falls.
        t0   = cyc;
        busy = 1'b1;
        btn  = 1'b1;
        at(t0 + 8);  check("s3_state_pend", 32'(dut.r_state), 32'(PEND));
        at(t0 + 10); busy = 1'b0;
        expect_pulse(1'b0, t0 + 11);
        at(t0 + 11); btn = 1'b0;
        at(t0 + 12); check("s3_state_held", 32'(dut.r_state), 32'(HELD));
        at(t0 + 25);

        // Press, release, re-press while busy: one drop, one start.
        t0   = cyc;
        busy = 1'b1;
        btn  = 1'b1;
        at(t0 + 7);  btn = 1'b0;
        at(t0 + 14); btn = 1'b1;
        expect_pulse(1'b1, t0 + 21);
        at(t0 + 22); check("s4_state_pend", 32'(dut.r_state), 32'(PEND));
        at(t0 + 24); busy = 1'b0;
        expect_pulse(1'b0, t0 + 25);
        at(t0 + 25); btn = 1'b0;
        at(t0 + 40); check("s4_state_idle", 32'(dut.r_state), 32'(IDLE));

        // Reset while PEND discards the held request.
        t0   = cyc;
        busy = 1'b1;
        btn  = 1'b1;
        at(t0 + 8);  check("s5_state_pend", 32'(dut.r_state), 32'(PEND));
        btn = 1'b0;
        at(t0 + 9);  rst = 1'b1;
        at(t0 + 10);
        check("s5_rst_level", 32'(level), 32'd0);
        check("s5_rst_start", 32'(start), 32'd0);
        check("s5_rst_drop",  32'(drop),  32'd0);
        check("s5_rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        at(t0 + 12); busy = 1'b0;
        at(t0 + 30);
        check("s5_state_idle", 32'(dut.r_state), 32'(IDLE));

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_start_gen
`default_nettype wire
